// File: rtl/nibble_add_seq.sv
// Multi-cycle wide adder: one shared 4-bit adder steps through NIBBLES slices, LSB first.
// Optional NIBBLE_ADD_SEQ_SUB_EN adds a 'sub' input giving a - b via ~b and carry-in 1.

module nibble_fa4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_add_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
   input  logic                 sub,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state, w_next;
   logic [W-1:0]    r_opA, r_opB, r_sum;
   logic [IW-1:0]   r_idx;
   logic            r_carry, r_cout;
   logic            w_accept, w_last;
   logic [W-1:0]    w_b_ld;
   logic            w_c_ld;
   logic [3:0]      w_ns;
   logic            w_co;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
   assign w_b_ld = sub ? ~b : b;
   assign w_c_ld = sub ? 1'b1 : cin;
`else
   assign w_b_ld = b;
   assign w_c_ld = cin;
`endif

   assign w_last = (r_idx == IW'(NIBBLES - 1));

   nibble_fa4 u_fa (
      .a  (r_opA[4*r_idx +: 4]),
      .b  (r_opB[4*r_idx +: 4]),
      .ci (r_carry),
      .s  (w_ns),
      .co (w_co)
   );

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_accept = 1'b1;
            w_next   = S_RUN;
         end
         S_RUN:  if (w_last) w_next = S_DONE;
         S_DONE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_opA   <= '0;
         r_opB   <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_opA   <= a;
            r_opB   <= w_b_ld;
            r_carry <= w_c_ld;
            r_idx   <= '0;
         end else if (r_state == S_RUN) begin
            // Upper nibbles keep stale data until their step writes them.
            r_sum[4*r_idx +: 4] <= w_ns;
            r_carry             <= w_co;
            if (w_last) r_cout <= w_co;
            else        r_idx  <= r_idx + 1'b1;
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: arithmetic model checked every cycle plus literal pins.
// Build with NIBBLE_ADD_SEQ_SUB_EN defined to also exercise subtraction.
module tb_nibble_add_seq;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   nibble_add_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   // Model: remaining busy cycles and the arithmetic result of the accepted request.
   int           m_rem = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_sum = '0, p_sum = '0;
   logic         m_cout = 1'b0, p_cout = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem <= 0; m_done <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
      end else if (m_rem != 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_done <= 1'b1; m_sum <= p_sum; m_cout <= p_cout;
         end else m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (start) begin
            m_rem <= N;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            if (sub) {p_cout, p_sum} <= {1'b0, a} + {1'b0, ~b} + 17'd1;
            else
`endif
            {p_cout, p_sum} <= {1'b0, a} + {1'b0, b} + {16'd0, cin};
         end
      end
   end

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("busy", {16'd0, busy}, {16'd0, (m_rem != 0)});
      check("done", {16'd0, done}, {16'd0, m_done});
      if (m_rem == 0) check("result", {cout, sum}, {m_cout, m_sum});
   end

   task automatic go(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
      @(posedge clk); #1;
      start = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits at negedges for done; returns the negedge count taken (0 on timeout).
   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      if (n == 0) begin
         errors++; vectors++;
         $display("FAIL done_timeout: got no done expected done within 20 cycles");
      end
   endtask

   int n, pulses;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset", {busy, done, cout, sum}, 19'd0);
      rst = 1'b0;

      go(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_done(n);
      check("latency", W'(n) , 17'd5);
      check("sum_5555", {cout, sum}, {1'b0, 16'h5555});

      go(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(n);
      check("ripple", {cout, sum}, {1'b1, 16'h0000});

      // Back-to-back: start stays high through DONE with new operands.
      @(posedge clk); #1;
      start = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b1;
      wait_done(n);
      check("cin_wrap", {cout, sum}, {1'b1, 16'h0000});
      a = 16'h0001; b = 16'h0002; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      check("b2b_gap", W'(n), 17'd5);
      check("b2b_sum", {cout, sum}, {1'b0, 16'h0003});

      // start pulsed mid-RUN must be ignored.
      go(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; a = 16'hAAAA; b = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            check("ignore_sum", {cout, sum}, {1'b0, 16'h1010});
         end
      end
      check("one_done", W'(pulses), 17'd1);

      // Reset mid-RUN.
      go(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      check("rst_async", {busy, done, cout, sum}, 19'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("no_done_after_rst", W'(pulses), 17'd0);
      go(16'h0100, 16'h0200, 1'b1, 1'b0);
      wait_done(n);
      check("after_rst", {cout, sum}, {1'b0, 16'h0301});

`ifdef NIBBLE_ADD_SEQ_SUB_EN
      go(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done(n);
      check("sub_neg", {cout, sum}, {1'b0, 16'hFFFE});
      go(16'h0007, 16'h0005, 1'b0, 1'b1);
      wait_done(n);
      check("sub_pos", {cout, sum}, {1'b1, 16'h0002});
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle wide adder that reuses a single 4-bit full-adder datapath (a, b, cin → sum, cout) to add NIBBLES×4-bit operands one nibble per clock, least-significant nibble first. It captures operands on a start request, moves the carry between nibble steps in a register, assembles the wide result, and reports completion with a one-cycle done pulse. It sits between a requesting controller and the shared 4-bit adder, trading latency for area.

## Interface
- NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4×NIBBLES; legal range 2..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  W  operand A; captured on accepted start.
- b  in  W  operand B; captured on accepted start.
- cin  in  1  carry-in to nibble 0; captured on accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; sum/cout valid.
- sum  out  W  result; held until the next accepted start.
- cout  out  1  carry out of the top nibble; held with sum.

## Operation
- Three FSM states: IDLE, RUN and DONE.
- IDLE:
  - start=1 → latch a, b and cin into internal registers (opA, opB, carry); idx=0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, once per cycle:
  - The 4-bit adder computes opA[idx], opB[idx] and carry.
  - The nibble result is written to sum[4·idx+3:4·idx].
  - carry ← adder cout.
  - If idx = NIBBLES−1: cout ← adder cout and go to DONE. Otherwise idx ← idx+1.
  - start is ignored while in RUN. There is no queueing; the requester must wait for done.
- DONE (exactly one cycle):
  - done=1.
  - start=1 → back-to-back accept with the same actions as from IDLE; go to RUN.
  - start=0 → go to IDLE.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(W+1). The idx counter is ceil(log2(NIBBLES)) bits and never wraps past NIBBLES−1.
- sum nibbles not yet written during RUN keep their previous values. Consumers read sum only when done=1 or afterwards.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, idx=0, carry=0.
- Latency:
  - start sampled at edge E0.
  - busy is high for edges E0+1 .. E0+NIBBLES.
  - done is high in the cycle following edge E0+NIBBLES (one cycle).
  - Total: NIBBLES+1 cycles from accept to done.
- Throughput: one operation per NIBBLES+1 cycles when start is held high continuously.
- Reset asserted mid-RUN: all outputs go to their reset values asynchronously. The partial result is discarded and no done is produced. Operation resumes in IDLE on the first edge after reset deasserts.
- start coincident with reset release edge: ignored, because reset takes priority.

## Configuration
- NIBBLE_ADD_SEQ_SUB_EN:
  - Defined: adds input port sub (1 bit), captured on accept.
  - sub=1 gives the result a − b with cin ignored: opB is stored as ~b and the initial carry is 1. cout=1 means no borrow.
  - sub=0 behaves identically to the build without the macro.
- Undefined: there is no sub port and the block only adds.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, cin=0, start one cycle → busy for 4 cycles; done on cycle 5; sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. The carry must ripple through all four nibble steps.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1. Then start held high in DONE with a=0x0001, b=0x0002 → re-accepted with no idle cycle; next done gives sum=0x0003.
- start pulsed during RUN with different operands → ignored; the first result is unaffected and exactly one done pulse occurs.
- rst asserted after 2 RUN cycles → busy, done, sum and cout are 0 immediately; no done after release; a new start completes normally.
- With NIBBLE_ADD_SEQ_SUB_EN defined, sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. With a=0x0007, b=0x0005 → sum=0x0002, cout=1.
